// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
// Occupancy and almost-full flag support upstream flow control.
module stream_fifo #(
    parameter int WIDTH       = 10,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push_valid,
    output logic                       o_push_ready,
    input  logic [WIDTH-1:0]           i_push_data,
    output logic                       o_pop_valid,
    input  logic                       i_pop_ready,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Full/empty come from the count so pointers may wrap freely.
    always_comb begin
        full          = (count == CW'(DEPTH));
        empty         = (count == '0);
        o_push_ready  = !full;
        o_pop_valid   = !empty;
        o_pop_data    = mem[rd_ptr];
        o_count       = count;
        o_almost_full = (count >= CW'(AFULL_LEVEL));
        push          = i_push_valid && !full;
        pop           = i_pop_ready && !empty;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= i_push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Randomised plus directed bench for stream_fifo, checked against a
// queue-based model of an in-order FIFO with DEPTH entries.
module tb_stream_fifo;

    localparam int W  = 10;
    localparam int D  = 4;
    localparam int AF = 3;
    localparam int CW = $clog2(D+1);

    logic          i_clk;
    logic          i_rst;
    logic          i_push_valid;
    logic          o_push_ready;
    logic [W-1:0]  i_push_data;
    logic          o_pop_valid;
    logic          i_pop_ready;
    logic [W-1:0]  o_pop_data;
    logic [CW-1:0] o_count;
    logic          o_almost_full;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    int           sz;
    logic         do_pop;
    logic         do_push;

    stream_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_LEVEL(AF)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_push_valid  (i_push_valid),
        .o_push_ready  (o_push_ready),
        .i_push_data   (i_push_data),
        .o_pop_valid   (o_pop_valid),
        .i_pop_ready   (i_pop_ready),
        .o_pop_data    (o_pop_data),
        .o_count       (o_count),
        .o_almost_full (o_almost_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every visible output against the model between edges,
    // then applies the transfers the upcoming rising edge will perform.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            chk("rst_push_ready", int'(o_push_ready), 1);
            chk("rst_pop_valid", int'(o_pop_valid), 0);
            chk("rst_count", int'(o_count), 0);
            chk("rst_almost_full", int'(o_almost_full), 0);
            chk("rst_pop_data", int'(o_pop_data), 0);
            exp_q.delete();
        end else begin
            sz = exp_q.size();
            chk("push_ready", int'(o_push_ready), int'(sz < D));
            chk("pop_valid", int'(o_pop_valid), int'(sz > 0));
            chk("count", int'(o_count), sz);
            chk("almost_full", int'(o_almost_full), int'(sz >= AF));
            if (sz > 0) chk("pop_data", int'(o_pop_data), int'(exp_q[0]));
            do_pop  = i_pop_ready && (sz > 0);
            do_push = i_push_valid && (sz < D);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(i_push_data);
        end
    end

    task automatic cyc(input logic pv, input logic [W-1:0] d, input logic pr);
        i_push_valid = pv;
        i_push_data  = d;
        i_pop_ready  = pr;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst        = 1'b0;
        i_push_valid = 1'b0;
        i_push_data  = '0;
        i_pop_ready  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        chk("idle_pop_data", int'(o_pop_data), 0);
        chk("idle_push_ready", int'(o_push_ready), 1);

        // Fill to full with the consumer stalled.
        cyc(1, 10'h001, 0);
        chk("first_visible", int'(o_pop_data), 'h001);
        cyc(1, 10'h002, 0);
        cyc(1, 10'h003, 0);
        chk("afull_at_3", int'(o_almost_full), 1);
        cyc(1, 10'h3FF, 0);
        chk("full_count", int'(o_count), 4);
        chk("full_ready", int'(o_push_ready), 0);

        // Pop from full while a push is held: push must be refused that cycle.
        cyc(1, 10'h155, 1);
        chk("after_pop_count", int'(o_count), 3);
        chk("after_pop_ready", int'(o_push_ready), 1);
        cyc(1, 10'h155, 0);
        chk("refill_count", int'(o_count), 4);
        repeat (5) cyc(0, '0, 1);
        chk("drained", int'(o_count), 0);

        // Steady push+pop at count 2 across pointer wrap.
        cyc(1, 10'h00E, 0);
        cyc(1, 10'h00F, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, W'(16 + i), 1);
            chk("wrap_count", int'(o_count), 2);
        end
        repeat (3) cyc(0, '0, 1);

        // Push into empty with the consumer always ready.
        cyc(1, 10'h0AB, 1);
        chk("empty_push_valid", int'(o_pop_valid), 1);
        cyc(0, '0, 1);
        chk("empty_push_gone", int'(o_count), 0);

        // Randomised traffic, biased toward filling then toward draining.
        for (int i = 0; i < 400; i++) begin
            if (i < 200) cyc($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 9) < 4);
            else         cyc($urandom_range(0, 9) < 4, W'($urandom), $urandom_range(0, 9) < 7);
        end
        repeat (6) cyc(0, '0, 1);

        // Asynchronous reset between edges with three entries held.
        repeat (3) cyc(1, W'($urandom), 0);
        chk("pre_reset_count", int'(o_count), 3);
        #2;
        i_rst = 1'b0;
        #1;
        chk("async_count", int'(o_count), 0);
        chk("async_pop_valid", int'(o_pop_valid), 0);
        chk("async_push_ready", int'(o_push_ready), 1);
        chk("async_pop_data", int'(o_pop_data), 0);
        chk("async_afull", int'(o_almost_full), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        cyc(1, 10'h2AA, 0);
        chk("post_reset_head", int'(o_pop_data), 'h2AA);
        cyc(0, '0, 1);
        chk("post_reset_empty", int'(o_count), 0);
        repeat (2) cyc(0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parameterised synchronous first-word-fall-through FIFO with valid/ready handshakes on both sides.
- Sits directly upstream of the 10-bit datapath modules and feeds their `b`-type data input.
- Decouples a bursty producer from a consumer that stalls.
- Reports occupancy and an almost-full threshold for upstream flow control.

Parameters:
- WIDTH, 10, data width in bits; legal range 1 or more.
- DEPTH, 4, number of entries; legal values are powers of two, 2 or more.
- AFULL_LEVEL, 3, o_almost_full asserts when count >= AFULL_LEVEL; legal range 1..DEPTH.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-low; asserted when 0.
- i_push_valid  input  1  producer has data.
- o_push_ready  output  1  FIFO can accept data; equals !full.
- i_push_data  input  WIDTH  write data.
- o_pop_valid  output  1  head entry is available; equals !empty.
- i_pop_ready  input  1  consumer accepts the head entry.
- o_pop_data  output  WIDTH  head entry (memory at read pointer).
- o_count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- o_almost_full  output  1  count >= AFULL_LEVEL.

Behaviour:
- Reset (i_rst=0, asynchronous assert, synchronous release):
  - Write pointer, read pointer and count clear to 0.
  - All storage entries clear to 0.
  - Outputs: o_push_ready=1, o_pop_valid=0, o_pop_data=0, o_count=0, o_almost_full=0 (AFULL_LEVEL >= 1).
- Transfer definitions:
  - push = i_push_valid & o_push_ready.
  - pop = o_pop_valid & i_pop_ready.
  - Only these qualified events change state. Valid asserted against ready=0 is ignored, not queued.
- Storage:
  - DEPTH x WIDTH register array.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0 by power-of-two overflow.
  - Full and empty are derived from count, not from pointer comparison.
- Push:
  - Writes i_push_data to mem[wr_ptr].
  - wr_ptr increments.
- Pop:
  - rd_ptr increments.
  - o_pop_data is combinational from mem[rd_ptr]. After a pop, the next entry appears in the same cycle the pointer updates.
- Count update: push only +1; pop only -1; both or neither unchanged.
- Latency:
  - A push into an empty FIFO is visible on o_pop_valid/o_pop_data one cycle later.
  - There is no combinational bypass from push to pop.
- Empty:
  - o_pop_valid=0.
  - o_pop_data shows the stale entry at rd_ptr; the consumer must ignore it.
  - Simultaneous push is accepted.
- Full:
  - o_push_ready=0, so push is blocked even if a pop occurs that cycle; there is no ready-on-pop path.
  - A pop frees the entry, and o_push_ready=1 on the next cycle.
- Simultaneous push and pop, with 0 < count < DEPTH:
  - Both complete.
  - Count is unchanged and both pointers advance.
- Outputs are combinational functions of registered state only. There is no input-to-output combinational path.
- Reset mid-operation: all contents are discarded and the FIFO returns to the reset state immediately, without waiting for a clock.

Test Plan:
- Reset then idle, DEPTH=4:
  - During and after reset: o_push_ready=1, o_pop_valid=0, o_count=0, o_almost_full=0, o_pop_data=0.
- Push 0x001, 0x002, 0x003, 0x3FF on consecutive cycles with i_pop_ready=0:
  - After the 1st push: o_pop_valid=1 with o_pop_data=0x001.
  - After the 3rd push: o_count=3, o_almost_full=1.
  - After the 4th push: o_count=4, o_push_ready=0.
- Full FIFO, hold i_push_valid=1 with data 0x155 and pulse i_pop_ready=1 for one cycle:
  - 0x001 is popped, 0x155 is not written that cycle.
  - Next cycle: o_push_ready=1, o_count=3.
  - 0x155 is written on the following cycle.
  - Drain order is 0x002, 0x003, 0x3FF, 0x155.
- Wrap-around: 10 cycles of simultaneous push and pop at count=2, data incrementing from 0x010:
  - o_count stays 2.
  - Output sequence is in order with no loss or duplication across pointer wrap.
- Push into empty with i_pop_ready=1 held:
  - o_pop_valid rises exactly one cycle after the push.
  - Data is popped on that cycle.
  - o_count returns to 0.
- Assert i_rst=0 asynchronously mid-cycle with count=3:
  - Outputs go to reset values before the next clock edge.
  - After release, the first push of 0x2AA is the first data out.
